keystream_cipher: RTL
=====================

// Module: keystream_cipher
// PURPOSE
//  Upstream stage of output_holder. Byte-serial LFSR stream cipher.
//  Takes one plaintext/ciphertext byte per request from the interface FSM and
//  generates 8 keystream bits by stepping a Galois LFSR once per cycle.
//  Emits byte XOR keystream with a 1-cycle pulse (data_out, data_out_pulse)
//  that output_holder latches. Encrypt and decrypt are the same operation.
// PARAMETERS
//  LFSR_W      16       LFSR width in bits
//  TAPS        16'hB400 Galois feedback mask (x^16+x^14+x^13+x^11+1)
//  RESET_SEED  16'hACE1 LFSR value after reset; must be nonzero
// PORTS
//  clk             in   1      system clock, rising edge
//  nrst            in   1      asynchronous active-low reset
//  seed_in         in   LFSR_W key/seed value
//  seed_load       in   1      1-cycle pulse: load seed_in into the LFSR
//  data_in         in   8      input byte
//  data_in_valid   in   1      1-cycle pulse: start processing data_in
//  data_out        out  8      result byte, held until the next pulse
//  data_out_pulse  out  1      1-cycle strobe: data_out is new (to output_holder)
//  busy            out  1      high while a byte is in flight
//  overrun         out  1      sticky: data_in_valid was dropped while busy
// BEHAVIOUR
//  Reset (nrst low, async): lfsr=RESET_SEED, state=IDLE, cnt=0, ks=0,
//   data_out=0, data_out_pulse=0, busy=0, overrun=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE : on data_in_valid, capture data_in into din_q; cnt=0; go to SHIFT.
//   SHIFT: each cycle ks<={ks[6:0],lfsr[0]};
//          lfsr<=(lfsr>>1)^(lfsr[0]?TAPS:0); cnt++. After 8 steps go to DONE.
//   DONE : data_out<=din_q^ks; data_out_pulse=1 this cycle only; go to IDLE.
//  Latency: valid sampled at edge 0; pulse is high in cycle 9 (8 SHIFT + 1 DONE).
//   Throughput is 1 byte per 10 cycles. A new valid is accepted the cycle after DONE.
//  busy=1 in SHIFT and DONE, 0 in IDLE. Registered, no combinational path to outputs.
//  The LFSR advances only in SHIFT. Keystream continues across bytes (no re-seed).
//  seed_load: lfsr<=seed_in. If seed_in==0, load 16'h0001 instead (avoids lockup).
//   In any state, seed_load wins: aborts the in-flight byte, gives no pulse,
//   returns to IDLE, clears overrun.
//  seed_load and data_in_valid in the same cycle: seed loads, data is dropped,
//   overrun is not set.
//  data_in_valid while busy (no seed_load): ignored; overrun<=1 (sticky).
//  data_out keeps its last value through abort and seed_load. Only DONE updates it.
//  Async reset mid-byte: everything returns to reset values; no pulse.
// CONFIGURATION
//  `CIPHER_BYPASS_EN defined: adds input port `bypass` (1 bit).
//   In IDLE with bypass=1, a data_in_valid goes directly to DONE (pulse 1 cycle
//   later, in cycle 1). Output is data_out=data_in and the LFSR is untouched.
//   With bypass=0, behaviour is as above.
//  `CIPHER_BYPASS_EN not defined: no bypass port. Every byte is ciphered with
//   10-cycle latency.
// TESTING
//  Reset: hold nrst low mid-SHIFT -> all outputs 0, lfsr=16'hACE1, no pulse.
//  seed_load 16'h0001, then data_in=8'h3C valid -> cycle 9: pulse=1,
//   data_out=8'hBC (ks=8'h80), lfsr=16'h0168.
//  Continue: data_in=8'h00 valid -> data_out=8'h16, lfsr=16'h7C41.
//   Reseed 16'h0001 and feed 8'hBC -> 8'h3C (round trip).
//  Valid pulsed again at cycle 4 of a byte -> ignored; overrun=1; exactly one
//   pulse. A later seed_load clears overrun.
//  seed_load 16'h0000 -> lfsr=16'h0001. A seed_load during SHIFT -> no pulse,
//   busy=0 next cycle, data_out unchanged.
//  With `CIPHER_BYPASS_EN defined, bypass=1, data_in=8'h5A -> pulse in cycle 1,
//   data_out=8'h5A, lfsr unchanged.

Source files
------------

// File: rtl/keystream_cipher_if.sv
// keystream_cipher_if
//   Byte/seed handshake bundle between the request FSM, keystream_cipher and
//   output_holder.
//   master : drives seed_in, seed_load, data_in, data_in_valid (and bypass when
//            CIPHER_BYPASS_EN is defined); observes the result signals.
//   slave  : the cipher; drives data_out, data_out_pulse, busy, overrun.
`timescale 1ns/1ps
interface keystream_cipher_if #(
    parameter int LFSR_W = 16
);
    logic [LFSR_W-1:0] seed_in;
    logic              seed_load;
    logic [7:0]        data_in;
    logic              data_in_valid;
    logic [7:0]        data_out;
    logic              data_out_pulse;
    logic              busy;
    logic              overrun;
`ifdef CIPHER_BYPASS_EN
    logic              bypass;
`endif

    modport master (
`ifdef CIPHER_BYPASS_EN
        output bypass,
`endif
        output seed_in, seed_load, data_in, data_in_valid,
        input  data_out, data_out_pulse, busy, overrun
    );

    modport slave (
`ifdef CIPHER_BYPASS_EN
        input  bypass,
`endif
        input  seed_in, seed_load, data_in, data_in_valid,
        output data_out, data_out_pulse, busy, overrun
    );
endinterface

// File: rtl/keystream_cipher.sv
// keystream_cipher
//   Byte-serial Galois-LFSR stream cipher (encrypt == decrypt). Each accepted
//   byte is XORed with 8 keystream bits produced by stepping the LFSR once per
//   cycle; the result is presented on data_out with a 1-cycle data_out_pulse.
//   Ports:
//     clk   : system clock, rising edge
//     nrst  : asynchronous active-low reset
//     bus   : keystream_cipher_if.slave (seed_in/seed_load, data_in/
//             data_in_valid, data_out/data_out_pulse, busy, overrun)
//   Optional feature macro: CIPHER_BYPASS_EN adds bus.bypass; a byte accepted
//   with bypass=1 skips the keystream and leaves the LFSR untouched.
`timescale 1ns/1ps
module keystream_cipher #(
    parameter int                 LFSR_W     = 16,
    parameter logic [LFSR_W-1:0]  TAPS       = 16'hB400,
    parameter logic [LFSR_W-1:0]  RESET_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             nrst,
    keystream_cipher_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [LFSR_W-1:0] SEED_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nx;
    logic [2:0]        cnt;
    logic [7:0]        din_q;
    logic [7:0]        ks;
    logic [LFSR_W-1:0] lfsr;
    logic              byp_sel;

`ifdef CIPHER_BYPASS_EN
    assign byp_sel = bus.bypass;
`else
    assign byp_sel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; seed_load overrides everything and aborts the byte
    always_comb begin
        state_nx = state;
        if (bus.seed_load) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.data_in_valid) state_nx = byp_sel ? S_DONE : S_SHIFT;
                S_SHIFT: if (cnt == 3'd7)       state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lfsr               <= RESET_SEED;
            cnt                <= '0;
            ks                 <= '0;
            din_q              <= '0;
            bus.data_out       <= '0;
            bus.data_out_pulse <= 1'b0;
            bus.busy           <= 1'b0;
            bus.overrun        <= 1'b0;
        end else begin
            // busy follows the state being entered, so it is glitch-free and registered
            bus.busy           <= (state_nx != S_IDLE);
            bus.data_out_pulse <= 1'b0;
            if (bus.seed_load) begin
                // A zero seed would lock the LFSR at zero forever
                lfsr        <= (bus.seed_in == '0) ? SEED_ONE : bus.seed_in;
                bus.overrun <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.data_in_valid) begin
                            din_q <= bus.data_in;
                            cnt   <= '0;
                            // Bypassed bytes XOR with zero in DONE
                            if (byp_sel) ks <= '0;
                        end
                    end
                    S_SHIFT: begin
                        ks   <= {ks[6:0], lfsr[0]};
                        lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
                        cnt  <= cnt + 3'd1;
                    end
                    S_DONE: begin
                        bus.data_out       <= din_q ^ ks;
                        bus.data_out_pulse <= 1'b1;
                    end
                    default: ;
                endcase
                if (bus.data_in_valid && (state != S_IDLE)) begin
                    bus.overrun <= 1'b1;
                end
            end
        end
    end
endmodule
